// File: rtl/core_pkg.sv
// core_pkg: shared hazard-control types and constants.
// Forward-select encodings, scoreboard slot layout, register match helper.
package core_pkg;

  localparam logic [1:0] FW_RF  = 2'b00;
  localparam logic [1:0] FW_MEM = 2'b01;
  localparam logic [1:0] FW_WB  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [4:0] addr;
    logic       load;
  } sb_slot_t;

  localparam int SB_SLOT_W = $bits(sb_slot_t);
  localparam int SB_DEPTH  = 3;
  localparam int SB_EX     = 0;
  localparam int SB_MEM    = 1;
  localparam int SB_WB     = 2;

  function automatic logic sb_match(
    input sb_slot_t   s,
    input logic [4:0] r
  );
    return s.valid & s.wr_en &
           (s.addr == r) & (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_sb_slot.sv
// hazard_sb_slot: one scoreboard slot register with hold and invalidate.
// Ports: clk, rst, hold (freeze), inv (load empty slot), d, q.
module hazard_sb_slot
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 inv,
  input  logic [SB_SLOT_W-1:0] d,
  output logic [SB_SLOT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= inv ? '0 : d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: interlock/bypass control, EX/MEM/WB scoreboard, mul/div busy.
// In: ID decode info, mem_stall. Out: stalls, bubble, comp muxes, fw selects,
// muldiv_busy; HAZARD_PERF_EN adds stall_cyc_cnt and bubble_cnt.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       rs_used_id,
  input  logic       rt_used_id,
  input  logic       wr_en_id,
  input  logic [4:0] wr_addr_id,
  input  logic       load_id,
  input  logic       cmp_id,
  input  logic       jr_id,
  input  logic       muldiv_start_id,
  input  logic       hilo_read_id,
  input  logic       mem_stall,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       reg_a_comp_mux,
  output logic       reg_b_comp_mux,
  output logic [1:0] fw_a_sel_ex,
  output logic [1:0] fw_b_sel_ex,
  output logic       muldiv_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cyc_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  sb_slot_t   sb_d [SB_DEPTH];
  sb_slot_t   sb_q [SB_DEPTH];
  sb_slot_t   ex_s, mem_s;
  logic [CNT_W-1:0] cnt;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, cmp_dep, jr_dep, md_dep;
  logic hazard, md_accept;
  logic [1:0] fw_a_d, fw_b_d;

  assign sb_d[SB_EX] = '{valid: id_valid, wr_en: wr_en_id,
                         addr: wr_addr_id, load: load_id};

  // EX <- ID, MEM <- EX, WB <- MEM; whole chain frozen on mem_stall
  for (genvar i = 0; i < SB_DEPTH; i++) begin : g_sb
    if (i > 0) begin : g_chain
      assign sb_d[i] = sb_q[i-1];
    end
    hazard_sb_slot u_slot (
      .clk  (clk),
      .rst  (rst),
      .hold (mem_stall),
      .inv  ((i == SB_EX) ? bubble_ex : 1'b0),
      .d    (sb_d[i]),
      .q    (sb_q[i])
    );
  end

  assign ex_s  = sb_q[SB_EX];
  assign mem_s = sb_q[SB_MEM];

  assign rs_ex  = sb_match(ex_s, rs_id);
  assign rt_ex  = sb_match(ex_s, rt_id);
  assign rs_mem = sb_match(mem_s, rs_id);
  assign rt_mem = sb_match(mem_s, rt_id);

  assign muldiv_busy = (cnt != '0);

  // WB writers need no check: the regfile writes before it is read
  always_comb begin
    load_use = ex_s.load &
               ((rs_used_id & rs_ex) | (rt_used_id & rt_ex));
    cmp_dep  = cmp_id &
               ((rs_used_id & (rs_mem | (rs_ex & ex_s.load))) |
                (rt_used_id & (rt_mem | (rt_ex & ex_s.load))));
    jr_dep   = jr_id & (rs_ex | rs_mem);
    md_dep   = (hilo_read_id | muldiv_start_id) & muldiv_busy;
    hazard   = id_valid & (load_use | cmp_dep | jr_dep | md_dep);
  end

  assign stall_if  = hazard | mem_stall;
  assign stall_id  = hazard | mem_stall;
  assign bubble_ex = hazard & ~mem_stall;

  // branch compare in ID can take the ALU result still sitting in EX
  assign reg_a_comp_mux = cmp_id & rs_used_id & rs_ex & ~ex_s.load;
  assign reg_b_comp_mux = cmp_id & rt_used_id & rt_ex & ~ex_s.load;

  // ID-time EX slot will be in MEM when this instruction reaches EX
  always_comb begin
    fw_a_d = rs_ex ? FW_MEM : (rs_mem ? FW_WB : FW_RF);
    fw_b_d = rt_ex ? FW_MEM : (rt_mem ? FW_WB : FW_RF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fw_a_sel_ex <= FW_RF;
      fw_b_sel_ex <= FW_RF;
    end else if (!mem_stall) begin
      fw_a_sel_ex <= bubble_ex ? FW_RF : fw_a_d;
      fw_b_sel_ex <= bubble_ex ? FW_RF : fw_b_d;
    end
  end

  assign md_accept = muldiv_start_id & id_valid &
                     ~hazard & ~mem_stall;

  // countdown keeps running through memory stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (md_accept) begin
      cnt <= CNT_W'(MULDIV_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_cnt <= '0;
      bubble_cnt    <= '0;
    end else begin
      if (stall_if && (stall_cyc_cnt != '1))
        stall_cyc_cnt <= stall_cyc_cnt + 32'd1;
      if (bubble_ex && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl (MULDIV_CYCLES=4).
// Driver queues expected outputs per cycle; a monitor pops and compares.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] rs_id, rt_id;
  logic       rs_used_id, rt_used_id;
  logic       wr_en_id;
  logic [4:0] wr_addr_id;
  logic       load_id, cmp_id, jr_id;
  logic       muldiv_start_id, hilo_read_id;
  logic       mem_stall;
  logic       stall_if, stall_id, bubble_ex;
  logic       reg_a_comp_mux, reg_b_comp_mux;
  logic [1:0] fw_a_sel_ex, fw_b_sel_ex;
  logic       muldiv_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cyc_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .rs_id           (rs_id),
    .rt_id           (rt_id),
    .rs_used_id      (rs_used_id),
    .rt_used_id      (rt_used_id),
    .wr_en_id        (wr_en_id),
    .wr_addr_id      (wr_addr_id),
    .load_id         (load_id),
    .cmp_id          (cmp_id),
    .jr_id           (jr_id),
    .muldiv_start_id (muldiv_start_id),
    .hilo_read_id    (hilo_read_id),
    .mem_stall       (mem_stall),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .bubble_ex       (bubble_ex),
    .reg_a_comp_mux  (reg_a_comp_mux),
    .reg_b_comp_mux  (reg_b_comp_mux),
    .fw_a_sel_ex     (fw_a_sel_ex),
    .fw_b_sel_ex     (fw_b_sel_ex),
    .muldiv_busy     (muldiv_busy)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cyc_cnt   (stall_cyc_cnt),
    .bubble_cnt      (bubble_cnt)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs, rt;
    logic       rsu, rtu, we;
    logic [4:0] wa;
    logic       ld, cmp, jr, md, hl;
  } ins_t;

  typedef struct {
    string      name;
    logic [9:0] v;
  } exp_t;

  exp_t sbq [$];
  int   checks = 0;
  int   errors = 0;

  function automatic ins_t nop();
    return '0;
  endfunction

  function automatic ins_t alu(int rd, int a, int b);
    ins_t i = '0;
    i.v = 1'b1; i.rs = 5'(a); i.rt = 5'(b);
    i.rsu = 1'b1; i.rtu = 1'b1;
    i.we = 1'b1; i.wa = 5'(rd);
    return i;
  endfunction

  function automatic ins_t lw(int rd, int base);
    ins_t i = '0;
    i.v = 1'b1; i.rs = 5'(base); i.rsu = 1'b1;
    i.rt = 5'(rd); i.we = 1'b1; i.wa = 5'(rd);
    i.ld = 1'b1;
    return i;
  endfunction

  function automatic ins_t beq(int a, int b);
    ins_t i = '0;
    i.v = 1'b1; i.rs = 5'(a); i.rt = 5'(b);
    i.rsu = 1'b1; i.rtu = 1'b1; i.cmp = 1'b1;
    return i;
  endfunction

  function automatic ins_t jr(int a);
    ins_t i = '0;
    i.v = 1'b1; i.rs = 5'(a); i.rsu = 1'b1; i.jr = 1'b1;
    return i;
  endfunction

  function automatic ins_t mult(int a, int b);
    ins_t i = '0;
    i.v = 1'b1; i.rs = 5'(a); i.rt = 5'(b);
    i.rsu = 1'b1; i.rtu = 1'b1; i.md = 1'b1;
    return i;
  endfunction

  function automatic ins_t mfhi(int rd);
    ins_t i = '0;
    i.v = 1'b1; i.we = 1'b1; i.wa = 5'(rd); i.hl = 1'b1;
    return i;
  endfunction

  // {stall_if, stall_id, bubble, comp_a, comp_b, fw_a, fw_b, busy}
  function automatic logic [9:0] ex(
    logic st, logic bu, logic ca, logic cb,
    logic [1:0] fa, logic [1:0] fb, logic busy
  );
    return {st, st, bu, ca, cb, fa, fb, busy};
  endfunction

  task automatic drive(input ins_t i, input logic ms, input logic r);
    rst             = r;
    mem_stall       = ms;
    id_valid        = i.v;
    rs_id           = i.rs;
    rt_id           = i.rt;
    rs_used_id      = i.rsu;
    rt_used_id      = i.rtu;
    wr_en_id        = i.we;
    wr_addr_id      = i.wa;
    load_id         = i.ld;
    cmp_id          = i.cmp;
    jr_id           = i.jr;
    muldiv_start_id = i.md;
    hilo_read_id    = i.hl;
  endtask

  task automatic cyc(
    input ins_t i, input logic ms, input logic r,
    input string nm, input logic [9:0] v
  );
    exp_t e;
    drive(i, ms, r);
    e.name = nm;
    e.v    = v;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic [9:0] got;
      e   = sbq.pop_front();
      got = {stall_if, stall_id, bubble_ex,
             reg_a_comp_mux, reg_b_comp_mux,
             fw_a_sel_ex, fw_b_sel_ex, muldiv_busy};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s got %b exp %b", e.name, got, e.v);
      end
    end
  end

  initial begin
    ins_t t;
    drive(nop(), 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    cyc(nop(), 0, 1, "rst_state",  ex(0,0,0,0,0,0,0));
    cyc(nop(), 1, 1, "rst_mstall", ex(1,0,0,0,0,0,0));

    cyc(lw(5,1),    0, 0, "lw_issue",   ex(0,0,0,0,0,0,0));
    cyc(alu(6,5,2), 0, 0, "ldu_stall",  ex(1,1,0,0,0,0,0));
    cyc(alu(6,5,2), 0, 0, "ldu_retry",  ex(0,0,0,0,0,0,0));
    cyc(nop(),      0, 0, "ldu_fw_wb",  ex(0,0,0,0,2'b10,0,0));

    cyc(alu(3,1,2), 0, 0, "add_r3",     ex(0,0,0,0,0,0,0));
    cyc(beq(3,4),   0, 0, "cmp_ex_fw",  ex(0,0,1,0,0,0,0));
    cyc(beq(3,0),   0, 0, "cmp_mem",    ex(1,1,0,0,2'b01,0,0));
    cyc(beq(3,0),   0, 0, "cmp_retry",  ex(0,0,0,0,0,0,0));

    cyc(alu(7,1,2), 0, 0, "sub_r7",     ex(0,0,0,0,0,0,0));
    cyc(alu(7,1,2), 0, 0, "add_r7",     ex(0,0,0,0,0,0,0));
    cyc(alu(8,7,7), 0, 0, "or_r7",      ex(0,0,0,0,0,0,0));
    cyc(alu(0,1,2), 0, 0, "fw_ex_prio", ex(0,0,0,0,2'b01,2'b01,0));
    cyc(alu(9,0,0), 0, 0, "rd_r0",      ex(0,0,0,0,0,0,0));
    cyc(lw(0,1),    0, 0, "r0_fw",      ex(0,0,0,0,0,0,0));
    cyc(alu(10,0,0),0, 0, "r0_ld_use",  ex(0,0,0,0,0,0,0));
    cyc(nop(),      0, 0, "r0_ld_fw",   ex(0,0,0,0,0,0,0));

    cyc(mult(1,2),  0, 0, "md_start",   ex(0,0,0,0,0,0,0));
    for (int k = 0; k < 4; k++)
      cyc(mfhi(11), 0, 0, "md_stall",   ex(1,1,0,0,0,0,1));
    cyc(mfhi(11),   0, 0, "md_done",    ex(0,0,0,0,0,0,0));

    cyc(lw(12,1),     0, 0, "lw_r12",    ex(0,0,0,0,0,0,0));
    cyc(alu(13,12,12),1, 0, "ms_ldu",    ex(1,0,0,0,0,0,0));
    cyc(alu(13,12,12),0, 0, "ms_reeval", ex(1,1,0,0,0,0,0));
    cyc(alu(13,12,12),0, 0, "ms_retry",  ex(0,0,0,0,0,0,0));
    cyc(nop(),        1, 0, "ms_hold",   ex(1,0,0,0,2'b10,2'b10,0));
    cyc(mult(13,13),  0, 0, "fw_held",   ex(0,0,0,0,2'b10,2'b10,0));
    cyc(nop(),        0, 1, "rst_mid",   ex(0,0,0,0,2'b01,2'b01,1));
    cyc(nop(),        0, 0, "post_rst",  ex(0,0,0,0,0,0,0));

    cyc(alu(14,1,2),  0, 0, "add_r14",   ex(0,0,0,0,0,0,0));
    cyc(jr(14),       0, 0, "jr_ex",     ex(1,1,0,0,0,0,0));
    cyc(jr(14),       0, 0, "jr_mem",    ex(1,1,0,0,0,0,0));
    cyc(jr(14),       0, 0, "jr_clear",  ex(0,0,0,0,0,0,0));

    cyc(lw(15,1),     0, 0, "lw_r15",    ex(0,0,0,0,0,0,0));
    t = alu(0,15,15);
    t.v = 1'b0;
    t.we = 1'b0;
    cyc(t,            0, 0, "id_inval",  ex(0,0,0,0,0,0,0));

    drive(nop(), 1'b0, 1'b0);
    for (int k = 0; k < 10 && sbq.size() > 0; k++)
      @(negedge clk);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sbq.size());
    end
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
